// File: rtl/sti_rx_unpack_if.sv
// Stream-in / pixel-memory-out bundle for the serial receive unpacker.
// master drives the serial stream; slave is the unpacker.
interface sti_rx_unpack_if #(
  parameter int ADDR_W = 8
);
  logic              so_data;
  logic              so_valid;
  logic [1:0]        frame_len;
  logic              frame_msb;
  logic              frame_end;
  logic [31:0]       word_data;
  logic              word_valid;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dataout;
  logic              len_err;
  logic              ovf_err;
  logic              done;

  modport master (
    output so_data, so_valid, frame_len, frame_msb, frame_end,
    input  word_data, word_valid, mem_wr, mem_addr, mem_dataout,
           len_err, ovf_err, done
  );

  modport slave (
    input  so_data, so_valid, frame_len, frame_msb, frame_end,
    output word_data, word_valid, mem_wr, mem_addr, mem_dataout,
           len_err, ovf_err, done
  );
endinterface

// File: rtl/sti_rx_unpack.sv
// Reassembles serial frames into words, writes them MSB byte first into pixel
// memory, and zero-fills the remaining memory after the last frame.
module sti_rx_unpack #(
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] FILL_VALUE = 8'h00
) (
  input  logic           clk_i,
  input  logic           reset_i,
  sti_rx_unpack_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RECV, CHECK, WRITE, FILL, DONE} state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q, state_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [1:0]        len_q, len_d;
  logic [1:0]        rem_q, rem_d;
  logic              msb_q, msb_d;
  logic              last_q, last_d;
  logic              wvld_q, wvld_d;
  logic              wr_q, wr_d;
  logic              lerr_q, lerr_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;

  logic [5:0]        exp_cnt;
  logic [1:0]        rem_m1;

  // (len+1)*8 without a multiplier: {len,111}+1
  assign exp_cnt = {1'b0, len_q, 3'b111} + 6'd1;
  assign rem_m1  = rem_q - 2'd1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    rem_d   = rem_q;
    msb_d   = msb_q;
    last_d  = last_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    wvld_d  = 1'b0;
    wr_d    = 1'b0;
    lerr_d  = 1'b0;

    if ((state_q == IDLE || state_q == RECV) && bus.frame_end) last_d = 1'b1;
    if (state_q != IDLE && state_q != RECV && bus.so_valid)    ovf_d  = 1'b1;

    case (state_q)
      IDLE: if (bus.so_valid) begin
        shift_d = {31'b0, bus.so_data};
        cnt_d   = 6'd1;
        len_d   = bus.frame_len;
        msb_d   = bus.frame_msb;
        state_d = RECV;
      end
      RECV: begin
        if (bus.so_valid) begin
          if (cnt_q < 6'd32) begin
            if (msb_q) shift_d = {shift_q[30:0], bus.so_data};
            else       shift_d[cnt_q[4:0]] = bus.so_data;
            cnt_d = cnt_q + 6'd1;
          end else begin
            cnt_d = 6'd33;
          end
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cnt_q == exp_cnt) begin
          wvld_d  = 1'b1;
          word_d  = shift_q;
          wr_d    = 1'b1;
          dout_d  = shift_q[{len_q, 3'b000} +: 8];
          rem_d   = len_q;
          state_d = WRITE;
        end else begin
          lerr_d = 1'b1;
          if (last_q) begin
            wr_d    = 1'b1;
            dout_d  = FILL_VALUE;
            state_d = FILL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        // address wraps silently here; only FILL stops at the top
        addr_d = addr_q + 1'b1;
        if (rem_q != 2'd0) begin
          wr_d   = 1'b1;
          dout_d = word_q[{rem_m1, 3'b000} +: 8];
          rem_d  = rem_m1;
        end else if (last_q) begin
          wr_d    = 1'b1;
          dout_d  = FILL_VALUE;
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (addr_q == ADDR_MAX) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          addr_d = addr_q + 1'b1;
          wr_d   = 1'b1;
          dout_d = FILL_VALUE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      msb_q   <= 1'b0;
      last_q  <= 1'b0;
      wvld_q  <= 1'b0;
      wr_q    <= 1'b0;
      lerr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      msb_q   <= msb_d;
      last_q  <= last_d;
      wvld_q  <= wvld_d;
      wr_q    <= wr_d;
      lerr_q  <= lerr_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.word_data   = word_q;
  assign bus.word_valid  = wvld_q;
  assign bus.mem_wr      = wr_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_dataout = dout_q;
  assign bus.len_err     = lerr_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sti_rx_unpack.sv
// Bench for sti_rx_unpack: directed cases plus random frames scored against
// a frame-level model of expected words, memory writes and length errors.
module tb_sti_rx_unpack;
  localparam int AW = 8;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  sti_rx_unpack_if #(.ADDR_W(AW)) bus();

  sti_rx_unpack #(.ADDR_W(AW), .FILL_VALUE(8'h00)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_wr[$];
  logic [31:0] exp_word[$];
  int          exp_addr = 0;
  int          exp_lerr = 0;
  int          seen_lerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write and every word pulse must match the model in order
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (bus.mem_wr) begin
        if (exp_wr.size() == 0) chk("unexpected_wr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        else begin
          int e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e[15:8]));
          chk("wr_data", 32'(bus.mem_dataout), 32'(e[7:0]));
        end
      end
      if (bus.word_valid) begin
        if (exp_word.size() == 0) chk("unexpected_word", bus.word_data, 32'hDEAD_0000);
        else chk("word_data", bus.word_data, exp_word.pop_front());
      end
      if (bus.len_err) seen_lerr++;
    end
  end

  task automatic model_frame(input int nbits, input logic [1:0] len, input logic [31:0] val,
                             input logic fend);
    int elen;
    logic [31:0] w;
    elen = 8 * (int'(len) + 1);
    if (nbits == elen) begin
      w = (elen == 32) ? val : (val & ((32'd1 << elen) - 32'd1));
      exp_word.push_back(w);
      for (int b = elen / 8 - 1; b >= 0; b--) begin
        exp_wr.push_back((exp_addr << 8) | int'((w >> (8 * b)) & 32'hFF));
        exp_addr = (exp_addr + 1) % (1 << AW);
      end
    end else begin
      exp_lerr++;
    end
    if (fend)
      for (int a = exp_addr; a < (1 << AW); a++) exp_wr.push_back(a << 8);
  endtask

  // returns with so_valid=0 just driven; later frame_len/msb bits are noise
  task automatic send_frame(input int nbits, input logic [1:0] len, input logic msb,
                            input logic [31:0] val, input logic fend);
    int idx;
    model_frame(nbits, len, val, fend);
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? (nbits - 1 - i) : i;
      bus.so_valid  = 1'b1;
      bus.so_data   = (idx < 32) ? val[idx] : 1'($urandom);
      bus.frame_len = (i == 0) ? len : 2'($urandom);
      bus.frame_msb = (i == 0) ? msb : 1'($urandom);
      bus.frame_end = fend && (i == nbits - 1);
      @(negedge clk_i);
    end
    bus.so_valid  = 1'b0;
    bus.frame_end = 1'b0;
  endtask

  task automatic settle();
    int b;
    b = 0;
    while (exp_wr.size() != 0 && b < 600) begin
      @(negedge clk_i);
      b++;
    end
    if (exp_wr.size() != 0) chk("settle_timeout", 32'(exp_wr.size()), 32'd0);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i       = 1'b1;
    bus.so_valid  = 1'b0;
    bus.so_data   = 1'b0;
    bus.frame_end = 1'b0;
    repeat (2) @(negedge clk_i);
    exp_wr.delete();
    exp_word.delete();
    exp_addr  = 0;
    exp_lerr  = 0;
    seen_lerr = 0;
    reset_i   = 1'b0;
  endtask

  task automatic wait_write_at(input int addr, input string tag);
    int b;
    b = 0;
    while (!(bus.mem_wr && int'(bus.mem_addr) == addr) && b < 600) begin
      @(negedge clk_i);
      b++;
    end
    chk(tag, 32'(bus.mem_addr), 32'(addr));
  endtask

  initial begin
    int a0, nb;
    logic [1:0] ln;
    bus.so_data = 1'b0; bus.so_valid = 1'b0; bus.frame_len = 2'd0;
    bus.frame_msb = 1'b0; bus.frame_end = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_word", bus.word_data, 32'd0);
    chk("rst_flags", {bus.word_valid, bus.len_err, bus.ovf_err, bus.done}, 32'd0);
    do_reset();

    // 8-bit MSB-first, first write lands two cycles after the gap
    send_frame(8, 2'b00, 1'b1, 32'hA5, 1'b0);
    @(negedge clk_i);
    chk("t1_no_wr_in_check", 32'(bus.mem_wr), 32'd0);
    @(negedge clk_i);
    chk("t1_first_wr", 32'(bus.mem_wr), 32'd1);
    chk("t1_word_valid", 32'(bus.word_valid), 32'd1);
    chk("t1_word", bus.word_data, 32'hA5);
    settle();

    // 32-bit LSB-first, four back-to-back writes
    do_reset();
    send_frame(32, 2'b11, 1'b0, 32'h1234_5678, 1'b0);
    repeat (2) @(negedge clk_i);
    for (int k = 0; k < 4; k++) begin
      chk("t2_consec_wr", 32'(bus.mem_wr), 32'd1);
      chk("t2_addr", 32'(bus.mem_addr), 32'(k));
      @(negedge clk_i);
    end
    settle();
    chk("t2_word_hold", bus.word_data, 32'h1234_5678);

    // short frame vs 16 expected
    a0 = int'(bus.mem_addr);
    send_frame(12, 2'b01, 1'b1, $urandom, 1'b0);
    settle();
    chk("t3_len_err", 32'(seen_lerr), 32'(exp_lerr));
    chk("t3_addr_kept", 32'(bus.mem_addr), 32'(a0));

    // so_valid during WRITE
    send_frame(32, 2'b11, 1'b1, 32'hCAFE_F00D, 1'b0);
    repeat (2) @(negedge clk_i);
    bus.so_valid = 1'b1;
    bus.so_data  = 1'b1;
    @(negedge clk_i);
    bus.so_valid = 1'b0;
    settle();
    chk("t5_ovf", 32'(bus.ovf_err), 32'd1);

    // random frames, a quarter with arbitrary bit counts
    do_reset();
    for (int f = 0; f < 40; f++) begin
      ln = 2'($urandom);
      nb = ($urandom % 4 != 0) ? 8 * (int'(ln) + 1) : int'($urandom_range(1, 36));
      send_frame(nb, ln, 1'($urandom), $urandom, 1'b0);
      settle();
    end
    chk("rnd_len_err_cnt", 32'(seen_lerr), 32'(exp_lerr));
    chk("rnd_addr", 32'(bus.mem_addr), 32'(exp_addr));
    chk("rnd_no_ovf", 32'(bus.ovf_err), 32'd0);
    chk("rnd_no_done", 32'(bus.done), 32'd0);
    chk("rnd_words_drained", 32'(exp_word.size()), 32'd0);

    // last frame at addr 10 then fill to the top
    do_reset();
    send_frame(32, 2'b11, 1'b1, $urandom, 1'b0); settle();
    send_frame(32, 2'b11, 1'b0, $urandom, 1'b0); settle();
    send_frame(16, 2'b01, 1'b1, $urandom, 1'b0); settle();
    chk("t4_start_addr", 32'(bus.mem_addr), 32'd10);
    send_frame(16, 2'b01, 1'b1, 32'hBEEF, 1'b1);
    wait_write_at(255, "t4_reach_top");
    chk("t4_not_done_yet", 32'(bus.done), 32'd0);
    @(negedge clk_i);
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_wr_off", 32'(bus.mem_wr), 32'd0);
    chk("t4_fill_drained", 32'(exp_wr.size()), 32'd0);
    repeat (3) @(negedge clk_i);
    chk("t4_done_sticky", 32'(bus.done), 32'd1);

    // reset in the middle of the fill
    do_reset();
    send_frame(8, 2'b00, 1'b1, 32'h3C, 1'b1);
    wait_write_at(100, "t6_reach_100");
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("t6_rst_wr", 32'(bus.mem_wr), 32'd0);
    chk("t6_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("t6_rst_data", 32'(bus.mem_dataout), 32'd0);
    chk("t6_rst_word", bus.word_data, 32'd0);
    chk("t6_rst_flags", {bus.word_valid, bus.len_err, bus.ovf_err, bus.done}, 32'd0);
    do_reset();
    repeat (3) @(negedge clk_i);
    chk("t6_idle_after", 32'(bus.mem_wr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
